// File: rtl/race_arbiter_n.sv
// Multi-player click race with a red-light elimination rule and a time-multiplexed
// per-player display that scans one player slot every SCAN_DIV cycles.
module race_arbiter_n #(
    parameter int unsigned NUM_PLAYERS = 4,
    parameter int unsigned STEP_W      = 4,
    parameter int unsigned SCAN_DIV    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   red,
    input  logic [NUM_PLAYERS-1:0] clicks,
    input  logic [3:0]             max_clicks,
    input  logic [STEP_W-1:0]      max_steps,
    output logic [2:0]             out_player_sel,
    output logic [STEP_W-1:0]      out_position,
    output logic [3:0]             out_status_code,
    output logic                   out_running,
    output logic                   out_game_over
);

    localparam int unsigned   DivW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
    localparam logic [2:0]    SelLast = 3'(NUM_PLAYERS - 1);
    localparam logic [3:0]    StatusRacing = 4'b1000;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e state_q, state_d;
    logic   running_q, running_d;
    logic   game_over_q, game_over_d;

    logic [NUM_PLAYERS-1:0][3:0]        cnt_q, cnt_d;
    logic [NUM_PLAYERS-1:0][STEP_W-1:0] pos_q, pos_d;
    logic [NUM_PLAYERS-1:0][3:0]        status_q, status_d;
    logic [NUM_PLAYERS-1:0]             active_q, active_d;
    logic [3:0]                         next_place_q, next_place_d;

    logic [DivW-1:0]   div_q, div_d;
    logic [2:0]        sel_q, sel_d;
    logic [STEP_W-1:0] out_pos_q, out_pos_d;
    logic [3:0]        out_status_q, out_status_d;

    logic [3:0]        eff_clicks;
    logic [STEP_W-1:0] eff_steps;
    logic [3:0]        place;
    logic [STEP_W-1:0] sel_pos;
    logic [3:0]        sel_status;

    assign eff_clicks = (max_clicks == 4'd0) ? 4'd1 : max_clicks;
    assign eff_steps  = (max_steps == '0) ? STEP_W'(1) : max_steps;

    // Race control and per-player state
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pos_d        = pos_q;
        status_d     = status_q;
        active_d     = active_q;
        next_place_d = next_place_q;
        place        = next_place_q;

        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (active_q == '0) state_d = StDone;
            StDone:  if (start) state_d = StRun;
            default: state_d = StIdle;
        endcase

        if (start && (state_q != StRun)) begin
            cnt_d        = '0;
            pos_d        = '0;
            status_d     = {NUM_PLAYERS{StatusRacing}};
            active_d     = '1;
            next_place_d = 4'd1;
        end else if (state_q == StRun) begin
            // Ascending index order gives lower players the better place on a tie
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                if (active_q[i] && clicks[i]) begin
                    if (red) begin
                        status_d[i] = 4'b0000;
                        active_d[i] = 1'b0;
                    end else if (cnt_q[i] >= eff_clicks - 4'd1) begin
                        cnt_d[i] = 4'd0;
                        pos_d[i] = pos_q[i] + STEP_W'(1);
                        if (pos_q[i] >= eff_steps - STEP_W'(1)) begin
                            status_d[i] = {1'b1, place[2:0]};
                            active_d[i] = 1'b0;
                            place       = place + 4'd1;
                        end
                    end else begin
                        cnt_d[i] = cnt_q[i] + 4'd1;
                    end
                end
            end
            next_place_d = place;
        end

        running_d   = (state_d == StRun);
        game_over_d = (state_d == StDone);
    end

    // Display scan
    always_comb begin
        sel_pos    = '0;
        sel_status = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (sel_q == 3'(i)) begin
                sel_pos    = pos_q[i];
                sel_status = status_q[i];
            end
        end

        div_d        = div_q + DivW'(1);
        sel_d        = sel_q;
        out_pos_d    = out_pos_q;
        out_status_d = out_status_q;
        if (div_q == DivLast) begin
            div_d        = '0;
            sel_d        = (sel_q == SelLast) ? 3'd0 : sel_q + 3'd1;
            out_pos_d    = sel_pos;
            out_status_d = sel_status;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            running_q    <= 1'b0;
            game_over_q  <= 1'b0;
            cnt_q        <= '0;
            pos_q        <= '0;
            status_q     <= {NUM_PLAYERS{StatusRacing}};
            active_q     <= '1;
            next_place_q <= 4'd1;
            div_q        <= '0;
            sel_q        <= '0;
            out_pos_q    <= '0;
            out_status_q <= '0;
        end else begin
            state_q      <= state_d;
            running_q    <= running_d;
            game_over_q  <= game_over_d;
            cnt_q        <= cnt_d;
            pos_q        <= pos_d;
            status_q     <= status_d;
            active_q     <= active_d;
            next_place_q <= next_place_d;
            div_q        <= div_d;
            sel_q        <= sel_d;
            out_pos_q    <= out_pos_d;
            out_status_q <= out_status_d;
        end
    end

    assign out_player_sel  = sel_q;
    assign out_position    = out_pos_q;
    assign out_status_code = out_status_q;
    assign out_running     = running_q;
    assign out_game_over   = game_over_q;

endmodule

// File: tb/tb_race_arbiter_n.sv
// Directed bench for race_arbiter_n: a 4-player instance for the race scenarios and a
// 3-player instance for the display scan sequence.
module tb_race_arbiter_n;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       red;
    logic [3:0] clicks;
    logic [3:0] max_clicks;
    logic [3:0] max_steps;

    logic [2:0] sel, sel3;
    logic [3:0] pos, pos3;
    logic [3:0] st, st3;
    logic       run, run3;
    logic       go, go3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    race_arbiter_n #(.NUM_PLAYERS(4), .STEP_W(4), .SCAN_DIV(2)) dut (
        .clk(clk), .rst(rst), .start(start), .red(red), .clicks(clicks),
        .max_clicks(max_clicks), .max_steps(max_steps),
        .out_player_sel(sel), .out_position(pos), .out_status_code(st),
        .out_running(run), .out_game_over(go)
    );

    race_arbiter_n #(.NUM_PLAYERS(3), .STEP_W(4), .SCAN_DIV(2)) dut3 (
        .clk(clk), .rst(rst), .start(start), .red(red), .clicks(clicks[2:0]),
        .max_clicks(max_clicks), .max_steps(max_steps),
        .out_player_sel(sel3), .out_position(pos3), .out_status_code(st3),
        .out_running(run3), .out_game_over(go3)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic click(input logic [3:0] mask, input int n);
        repeat (n) begin
            clicks = mask;
            tick();
        end
        clicks = 4'b0000;
    endtask

    // Wait for the slot edge that leaves player p, then the outputs hold p's state
    task automatic read_player(input int p, input int exp_pos, input int exp_st,
                               input string tag);
        logic [2:0] prev;
        logic [2:0] nxt;
        bit         found;
        found = 1'b0;
        nxt   = 3'((p + 1) % 4);
        prev  = sel;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            if (prev == 3'(p) && sel == nxt) found = 1'b1;
            else prev = sel;
        end
        check_eq({tag, "_slot"}, 32'(found), 32'd1);
        check_eq({tag, "_pos"}, 32'(pos), 32'(exp_pos));
        check_eq({tag, "_st"}, 32'(st), 32'(exp_st));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_sel[8] = '{0, 1, 1, 2, 2, 0, 0, 1};

        rst        = 1'b0;
        start      = 1'b0;
        red        = 1'b0;
        clicks     = 4'b0000;
        max_clicks = 4'd2;
        max_steps  = 4'd3;

        // Reset state
        #12;
        check_eq("rst_sel", 32'(sel), 32'd0);
        check_eq("rst_pos", 32'(pos), 32'd0);
        check_eq("rst_st", 32'(st), 32'd0);
        check_eq("rst_run", 32'(run), 32'd0);
        check_eq("rst_go", 32'(go), 32'd0);
        check_eq("rst_run3", 32'({run3, go3, pos3}), 32'd0);
        #10 rst = 1'b1;

        // Scan wrap on the 3-player instance
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq($sformatf("scan_sel_%0d", i), 32'(sel3), 32'(exp_sel[i]));
            if (i == 0) check_eq("scan_st_pre", 32'(st3), 32'd0);
            if (i == 1) check_eq("scan_st_p0", 32'(st3), 32'd8);
        end
        check_eq("idle_run", 32'(run), 32'd0);

        // Race A: basic finish
        pulse_start();
        check_eq("a_run", 32'(run), 32'd1);
        click(4'b0001, 6);
        read_player(0, 3, 9, "a_p0");
        read_player(1, 0, 8, "a_p1");

        // Start during RUN is ignored
        pulse_start();
        read_player(0, 3, 9, "a_p0_keep");
        check_eq("a_run_keep", 32'(run), 32'd1);

        // Red elimination of player 2 at position 1
        click(4'b0100, 2);
        red = 1'b1;
        click(4'b0100, 1);
        red = 1'b0;
        click(4'b0100, 4);
        read_player(2, 1, 0, "a_p2_elim");

        // Players 1 and 3 finish together with next_place 2
        click(4'b1010, 6);
        check_eq("a_go_early", 32'(go), 32'd0);
        tick();
        check_eq("a_go", 32'(go), 32'd1);
        check_eq("a_run_off", 32'(run), 32'd0);
        read_player(1, 3, 10, "a_p1");
        read_player(3, 3, 11, "a_p3");

        // Restart from DONE clears everyone
        pulse_start();
        check_eq("b_run", 32'(run), 32'd1);
        check_eq("b_go", 32'(go), 32'd0);
        read_player(0, 0, 8, "b_p0_clr");
        read_player(3, 0, 8, "b_p3_clr");

        // Race B: simultaneous finish from next_place 1
        click(4'b1010, 6);
        read_player(1, 3, 9, "b_p1");
        read_player(3, 3, 10, "b_p3");
        click(4'b0001, 6);
        read_player(0, 3, 11, "b_p0_place3");

        // Zero limits act as one click and one step
        max_clicks = 4'd0;
        max_steps  = 4'd0;
        click(4'b0100, 1);
        read_player(2, 1, 12, "b_p2_zero");
        check_eq("b_go", 32'(go), 32'd1);
        max_clicks = 4'd2;
        max_steps  = 4'd3;

        // Race C: async reset mid-race
        pulse_start();
        click(4'b0001, 2);
        #2 rst = 1'b0;
        #1;
        check_eq("c_rst_run", 32'(run), 32'd0);
        check_eq("c_rst_sel", 32'(sel), 32'd0);
        check_eq("c_rst_st", 32'(st), 32'd0);
        check_eq("c_rst_pos", 32'(pos), 32'd0);
        check_eq("c_rst_go", 32'(go), 32'd0);
        #10 rst = 1'b1;
        tick();
        check_eq("c_idle_run", 32'(run), 32'd0);
        check_eq("c_idle_st", 32'(st), 32'd0);
        click(4'b0001, 6);
        read_player(0, 0, 8, "c_p0_ignored");
        pulse_start();
        check_eq("c_run", 32'(run), 32'd1);
        read_player(0, 0, 8, "c_p0_fresh");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
